// File: rtl/mux_src_sequencer.sv
// mux_src_sequencer: pairs a byte stream into atomically committed A/B operands and scans sel with a programmable dwell
module mux_src_sequencer #(
    parameter int DATA_W = 8,
    parameter int DWELL  = 50000,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              freeze,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic              sel,
    output logic              pair_valid,
    output logic              swap_pulse
);
    typedef enum logic {WAIT_A, WAIT_B} state_t;
    state_t state, state_n;
    logic [DATA_W-1:0] shadow_a;
    logic [CNT_W-1:0] cnt;
    logic accept, commit, last;
    assign in_ready = ~rst & ~freeze;
    assign accept = in_valid & in_ready;
    assign commit = accept & (state == WAIT_B);
    assign last = cnt == CNT_W'(DWELL - 1);
    // pairing state flips on every accepted byte
    always_comb begin
        state_n = state;
        if (accept) state_n = (state == WAIT_A) ? WAIT_B : WAIT_A;
    end
    // pairing state register; reset discards a half-received pair
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= WAIT_A;
        else state <= state_n;
    end
    // first byte of a pair waits here so A/B update together
    always_ff @(posedge clk or posedge rst) begin
        if (rst) shadow_a <= '0;
        else if (accept && state == WAIT_A) shadow_a <= in_data;
    end
    // commit restarts the A phase and wins over a coincident dwell toggle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            A <= '0;
            B <= '0;
            pair_valid <= 1'b0;
            sel <= 1'b1;
            cnt <= '0;
            swap_pulse <= 1'b0;
        end else if (commit) begin
            A <= shadow_a;
            B <= in_data;
            pair_valid <= 1'b1;
            sel <= 1'b1;
            cnt <= '0;
            swap_pulse <= ~sel;
        end else if (pair_valid && !freeze) begin
            cnt <= last ? '0 : cnt + 1'b1;
            sel <= last ? ~sel : sel;
            swap_pulse <= last;
        end else begin
            swap_pulse <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mux_src_sequencer.sv
// tb_mux_src_sequencer: randomized and directed checks of pairing, commit and dwell scanning on DWELL=4 and DWELL=1 instances
module tb_mux_src_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic freeze = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic [7:0] da [2];
    logic [7:0] db [2];
    logic dsel [2];
    logic dpv [2];
    logic dsw [2];
    logic drdy [2];
    int q [$];
    logic [7:0] mA, mB;
    logic mpv;
    logic msel [2];
    logic msw [2];
    int el [2];
    int n_chk = 0;
    int n_fail = 0;

    mux_src_sequencer #(.DATA_W(8), .DWELL(4), .CNT_W(16)) u0 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(drdy[0]),
        .freeze(freeze), .A(da[0]), .B(db[0]), .sel(dsel[0]), .pair_valid(dpv[0]), .swap_pulse(dsw[0])
    );
    mux_src_sequencer #(.DATA_W(8), .DWELL(1), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(drdy[1]),
        .freeze(freeze), .A(da[1]), .B(db[1]), .sel(dsel[1]), .pair_valid(dpv[1]), .swap_pulse(dsw[1])
    );

    always #5 clk = ~clk;

    function automatic int dwell_of(int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic logic [19:0] obs(int i);
        return {da[i], db[i], dsel[i], dpv[i], dsw[i], drdy[i]};
    endfunction

    function automatic logic [19:0] expv(int i);
        return {mA, mB, msel[i], mpv, msw[i], ~rst & ~freeze};
    endfunction

    task automatic model_reset();
        q.delete();
        mA = 8'h00;
        mB = 8'h00;
        mpv = 1'b0;
        for (int i = 0; i < 2; i++) begin
            msel[i] = 1'b1;
            msw[i] = 1'b0;
            el[i] = 0;
        end
    endtask

    task automatic step();
        bit commit;
        commit = 0;
        if (!rst) begin
            if (in_valid && !freeze) begin
                q.push_back(int'(in_data));
                if (q.size() == 2) begin
                    commit = 1;
                    mA = 8'(q[0]);
                    mB = 8'(q[1]);
                    q.delete();
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (commit) begin
                    msw[i] = !msel[i];
                    msel[i] = 1'b1;
                    el[i] = 0;
                end else if (mpv && !freeze) begin
                    el[i]++;
                    msw[i] = (el[i] == dwell_of(i));
                    if (msw[i]) begin
                        el[i] = 0;
                        msel[i] = !msel[i];
                    end
                end else begin
                    msw[i] = 1'b0;
                end
            end
            if (commit) mpv = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            n_chk++;
            if (obs(i) !== expv(i)) begin n_fail++; $display("FAIL reset u%0d got {A,B,sel,pv,sw,rdy}=%h exp %h", i, obs(i), expv(i)); end
        end
        rst = 1'b0;
    endtask

    task automatic test_pair();
        in_valid = 1'b1;
        in_data = 8'h3C;
        step();
        in_data = 8'h5A;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_chk++;
            if (obs(i) !== expv(i)) begin n_fail++; $display("FAIL pair u%0d got {A,B,sel,pv,sw,rdy}=%h exp %h", i, obs(i), expv(i)); end
        end
        n_chk++;
        if ({da[0], db[0], dpv[0], dsel[0]} !== {8'h3C, 8'h5A, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL pair_const got A=%h B=%h pv=%b sel=%b exp 3c 5a 1 1", da[0], db[0], dpv[0], dsel[0]);
        end
    endtask

    task automatic test_dwell();
        for (int k = 1; k <= 17; k++) begin
            step();
            for (int i = 0; i < 2; i++) begin
                n_chk++;
                if (obs(i) !== expv(i)) begin n_fail++; $display("FAIL dwell u%0d k=%0d got %h exp %h", i, k, obs(i), expv(i)); end
            end
            n_chk++;
            if ({dsel[0], dsw[0]} !== {1'((k / 4) % 2 == 0), 1'(k % 4 == 0)}) begin
                n_fail++; $display("FAIL dwell_pattern k=%0d got sel=%b sw=%b", k, dsel[0], dsw[0]);
            end
        end
    endtask

    task automatic test_slow_pair();
        in_valid = 1'b1;
        in_data = 8'h11;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 11; k++) begin
            for (int i = 0; i < 2; i++) begin
                n_chk++;
                if (obs(i) !== expv(i)) begin n_fail++; $display("FAIL slow_pair u%0d k=%0d got %h exp %h", i, k, obs(i), expv(i)); end
            end
            if (k < 10) step();
        end
        n_chk++;
        if ({da[0], db[0]} !== {8'h3C, 8'h5A}) begin n_fail++; $display("FAIL slow_hold got A=%h B=%h exp 3c 5a", da[0], db[0]); end
        in_valid = 1'b1;
        in_data = 8'h22;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_chk++;
            if ({da[i], db[i], dsel[i]} !== {8'h11, 8'h22, 1'b1}) begin
                n_fail++; $display("FAIL slow_commit u%0d got A=%h B=%h sel=%b exp 11 22 1", i, da[i], db[i], dsel[i]);
            end
        end
    endtask

    task automatic test_freeze();
        repeat (2) step();
        freeze = 1'b1;
        in_valid = 1'b1;
        for (int k = 0; k < 7; k++) begin
            in_data = 8'($urandom);
            step();
            for (int i = 0; i < 2; i++) begin
                n_chk++;
                if (obs(i) !== expv(i)) begin n_fail++; $display("FAIL freeze u%0d k=%0d got %h exp %h", i, k, obs(i), expv(i)); end
            end
        end
        freeze = 1'b0;
        in_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            for (int i = 0; i < 2; i++) begin
                n_chk++;
                if (obs(i) !== expv(i)) begin n_fail++; $display("FAIL unfreeze u%0d k=%0d got %h exp %h", i, k, obs(i), expv(i)); end
            end
        end
    endtask

    task automatic test_reset_midpair();
        in_valid = 1'b1;
        in_data = 8'h77;
        step();
        in_valid = 1'b0;
        step();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            n_chk++;
            if (obs(i) !== expv(i)) begin n_fail++; $display("FAIL async_reset u%0d got %h exp %h", i, obs(i), expv(i)); end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b1;
        in_data = 8'hA1;
        step();
        in_data = 8'hB2;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_chk++;
            if ({da[i], db[i], dpv[i]} !== {8'hA1, 8'hB2, 1'b1}) begin
                n_fail++; $display("FAIL reset_discard u%0d got A=%h B=%h pv=%b exp a1 b2 1", i, da[i], db[i], dpv[i]);
            end
        end
    endtask

    task automatic test_dwell1_commit();
        in_valid = 1'b1;
        in_data = 8'hC3;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 4 && msel[1] != 1'b0; k++) step();
        n_chk++;
        if (dsel[1] !== 1'b0) begin n_fail++; $display("FAIL d1_pre got sel=%b exp 0", dsel[1]); end
        in_valid = 1'b1;
        in_data = 8'h3D;
        step();
        in_valid = 1'b0;
        n_chk++;
        if ({da[1], db[1], dsel[1], dsw[1]} !== {8'hC3, 8'h3D, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL d1_commit got A=%h B=%h sel=%b sw=%b exp c3 3d 1 1", da[1], db[1], dsel[1], dsw[1]);
        end
        step();
        n_chk++;
        if ({dsel[1], dsw[1]} !== 2'b01) begin n_fail++; $display("FAIL d1_next got sel=%b sw=%b exp 0 1", dsel[1], dsw[1]); end
        for (int i = 0; i < 2; i++) begin
            n_chk++;
            if (obs(i) !== expv(i)) begin n_fail++; $display("FAIL d1_model u%0d got %h exp %h", i, obs(i), expv(i)); end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            in_valid = 1'($urandom_range(0, 1));
            freeze = ($urandom_range(0, 7) == 0);
            in_data = 8'($urandom);
            step();
            for (int i = 0; i < 2; i++) begin
                n_chk++;
                if (obs(i) !== expv(i)) begin n_fail++; $display("FAIL random u%0d k=%0d got %h exp %h", i, k, obs(i), expv(i)); end
            end
        end
        in_valid = 1'b0;
        freeze = 1'b0;
    endtask

    initial begin
        test_reset();
        test_pair();
        test_dwell();
        test_slow_pair();
        test_freeze();
        test_reset_midpair();
        test_dwell1_commit();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
